// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the hazard scoreboard.
// Imported by the pend[] array and the scoreboard top.
package hazard_pkg;

    localparam int PEND_W       = 4;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MDU_LAT  = 4;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic {
        MDU_IDLE,
        MDU_BUSY
    } mdu_state_e;

    typedef enum logic [1:0] {
        LAT_ALU,
        LAT_LOAD,
        LAT_MDU
    } lat_class_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending counters: set on issue, count down to zero.
// Register 0 is never pending.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic [PEND_W-1:0] set_val,
    input  logic [ADDR_W-1:0] rs1_idx,
    input  logic [ADDR_W-1:0] rs2_idx,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [PEND_W-1:0] rs1_pend,
    output logic [PEND_W-1:0] rs2_pend,
    output logic [PEND_W-1:0] rd_pend
);

    localparam int NREG = 2 ** ADDR_W;

    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    // Decrement every live entry; a new issue to the same entry wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = (pend_q[r] == '0) ? '0 : pend_q[r] - 1'b1;
            if (set_en && set_idx == ADDR_W'(r))
                pend_d[r] = set_val;
        end
        pend_d[0] = '0;
    end

    // Pending counter storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= pend_d[r];
        end
    end

    assign rs1_pend = pend_q[rs1_idx];
    assign rs2_pend = pend_q[rs2_idx];
    assign rd_pend  = pend_q[rd_idx];

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: RAW/WAW/MDU-structural stalls, branch flushes,
// MDU occupancy FSM and a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MDU_LAT  = DEF_MDU_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [ADDR_W-1:0] rd_d,
    input  logic              valid_d,
    input  logic              regwrite_d,
    input  logic              is_load_d,
    input  logic              is_mdu_d,
    input  logic              pcsrc_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mdu_start,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    mdu_state_e        state_q, state_d;
    logic [PEND_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    lat_class_e        cls;
    logic [PEND_W-1:0] op_lat;
    logic [PEND_W-1:0] rs1_pend, rs2_pend, rd_pend;
    logic              wr_vld, raw, waw, strct, hazard, issue, set_en;

    // Latency class of the D-stage op; MDU takes precedence over load.
    always_comb begin
        cls = LAT_ALU;
        if (is_mdu_d)
            cls = LAT_MDU;
        else if (is_load_d)
            cls = LAT_LOAD;
        unique case (cls)
            LAT_MDU:  op_lat = PEND_W'(MDU_LAT);
            LAT_LOAD: op_lat = PEND_W'(LOAD_LAT);
            default:  op_lat = '0;
        endcase
    end

    assign wr_vld = valid_d & regwrite_d & (rd_d != '0);
    assign raw    = (use_rs1_d & (rs1_pend != '0))
                  | (use_rs2_d & (rs2_pend != '0));
    assign waw    = wr_vld & (rd_pend > op_lat);
    assign strct  = is_mdu_d & mdu_busy;
    assign hazard = valid_d & (raw | waw | strct);

    // Branch flush overrides stalls; everything is quiet in reset.
    always_comb begin
        flush_d   = reset & pcsrc_e;
        stall_d   = reset & ~pcsrc_e & hazard;
        stall_f   = stall_d;
        flush_e   = flush_d | stall_d;
        issue     = reset & valid_d & ~stall_d & ~flush_d;
        mdu_start = issue & is_mdu_d;
        set_en    = issue & wr_vld & (cls != LAT_ALU);
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_idx  (rd_d),
        .set_val  (op_lat),
        .rs1_idx  (rs1_d),
        .rs2_idx  (rs2_d),
        .rd_idx   (rd_d),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend)
    );

    // MDU occupancy FSM next state.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (mdu_start) begin
                    state_d = MDU_BUSY;
                    mcnt_d  = PEND_W'(MDU_LAT - 1);
                end
            end
            MDU_BUSY: begin
                if (mcnt_q == '0)
                    state_d = MDU_IDLE;
                else
                    mcnt_d = mcnt_q - 1'b1;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    assign mdu_busy = (state_q == MDU_BUSY);

    // Saturating stall counter next value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign stall_cnt = stall_cnt_q;

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MDU_IDLE;
            mcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random
// traffic against a ready-time model of register availability.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int LL = 1;
    localparam int ML = 4;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rs1_d, rs2_d, rd_d;
    logic          use_rs1_d, use_rs2_d;
    logic          valid_d, regwrite_d, is_load_d, is_mdu_d, pcsrc_e;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic          mdu_start, mdu_busy;
    logic [CW-1:0] stall_cnt;

    hazard_scoreboard #(
        .ADDR_W   (AW),
        .LOAD_LAT (LL),
        .MDU_LAT  (ML),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .use_rs1_d  (use_rs1_d),
        .use_rs2_d  (use_rs2_d),
        .rd_d       (rd_d),
        .valid_d    (valid_d),
        .regwrite_d (regwrite_d),
        .is_load_d  (is_load_d),
        .is_mdu_d   (is_mdu_d),
        .pcsrc_e    (pcsrc_e),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .mdu_start  (mdu_start),
        .mdu_busy   (mdu_busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready [32];
    int mdu_free = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        mdu_free = 0;
        exp_cnt = 0;
    endtask

    function automatic int pend(input int r);
        if (r == 0 || ready[r] <= cyc) return 0;
        return ready[r] - cyc;
    endfunction

    task automatic drive(input bit v, input bit ld, input bit md,
                         input bit rw, input int rd,
                         input int s1, input bit u1,
                         input int s2, input bit u2, input bit br);
        valid_d    = v;
        is_load_d  = ld;
        is_mdu_d   = md;
        regwrite_d = rw;
        rd_d       = AW'(rd);
        rs1_d      = AW'(s1);
        use_rs1_d  = u1;
        rs2_d      = AW'(s2);
        use_rs2_d  = u2;
        pcsrc_e    = br;
    endtask

    // Drive at the falling edge, check 1ns later, advance the model.
    task automatic step(input string tag, input bit v, input bit ld,
                        input bit md, input bit rw, input int rd,
                        input int s1, input bit u1,
                        input int s2, input bit u2, input bit br);
        int lat;
        bit haz, e_stall, e_issue, e_start, e_busy;
        @(negedge clk);
        drive(v, ld, md, rw, rd, s1, u1, s2, u2, br);
        #1;
        lat = md ? ML : (ld ? LL : 0);
        haz = v && ((u1 && pend(s1) > 0) || (u2 && pend(s2) > 0) ||
                    (rw && rd != 0 && pend(rd) > lat) ||
                    (md && mdu_free > cyc));
        e_stall = !br && haz;
        e_issue = v && !br && !haz;
        e_start = e_issue && md;
        e_busy  = mdu_free > cyc;
        chk({tag, ".stall_d"}, 32'(stall_d), 32'(e_stall));
        chk({tag, ".stall_f"}, 32'(stall_f), 32'(e_stall));
        chk({tag, ".flush_d"}, 32'(flush_d), 32'(br));
        chk({tag, ".flush_e"}, 32'(flush_e), 32'(br || e_stall));
        chk({tag, ".mdu_start"}, 32'(mdu_start), 32'(e_start));
        chk({tag, ".mdu_busy"}, 32'(mdu_busy), 32'(e_busy));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        if (e_issue && rw && rd != 0 && (ld || md))
            ready[rd] = cyc + 1 + lat;
        if (e_start)
            mdu_free = cyc + 1 + ML;
        if (e_stall && exp_cnt < CMAX)
            exp_cnt++;
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall_d"}, 32'(stall_d), 0);
        chk({tag, ".stall_f"}, 32'(stall_f), 0);
        chk({tag, ".flush_d"}, 32'(flush_d), 0);
        chk({tag, ".flush_e"}, 32'(flush_e), 0);
        chk({tag, ".mdu_start"}, 32'(mdu_start), 0);
        chk({tag, ".mdu_busy"}, 32'(mdu_busy), 0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
    endtask

    initial begin
        bit ld, md;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        cyc = 10;

        // load-use on x5: one bubble then issue
        step("ld5", 1, 1, 0, 1, 5, 0, 0, 0, 0, 0);
        step("use5a", 1, 0, 0, 1, 6, 5, 1, 0, 0, 0);
        chk("use5a_direct", 32'(stall_d), 1);
        step("use5b", 1, 0, 0, 1, 6, 0, 0, 5, 1, 0);
        chk("use5b_direct", 32'(stall_d), 0);
        step("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ld_use_cnt", 32'(stall_cnt), 1);

        // MDU to x7 then dependent: 4 stalls, issue on the 5th
        step("mdu7", 1, 0, 1, 1, 7, 1, 1, 2, 1, 0);
        chk("mdu7_start", 32'(mdu_start), 1);
        for (int i = 0; i < 5; i++)
            step("dep7", 1, 0, 0, 1, 3, 7, 1, 0, 0, 0);
        step("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mdu_cnt", 32'(stall_cnt), 5);

        // back-to-back MDU ops: second waits for the unit
        step("mdu8", 1, 0, 1, 1, 8, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("mdu10", 1, 0, 1, 1, 10, 0, 0, 0, 0, 0);

        // load-use coinciding with a taken branch
        step("ld5b", 1, 1, 0, 1, 5, 0, 0, 0, 0, 0);
        step("br5", 1, 0, 0, 1, 6, 5, 1, 0, 0, 1);
        chk("br5_stall", 32'(stall_d), 0);
        chk("br5_flush", 32'(flush_e), 1);
        step("use5c", 1, 0, 0, 1, 6, 5, 1, 0, 0, 0);
        chk("use5c_nostall", 32'(stall_d), 0);

        // WAW: ALU write to x9 behind an MDU write
        for (int i = 0; i < 6; i++)
            step("idle3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mdu9", 1, 0, 1, 1, 9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("waw9", 1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        step("ld0", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("use0", 1, 0, 0, 1, 0, 0, 1, 0, 1, 0);
        chk("x0_nostall", 32'(stall_d), 0);

        // reset while MDU busy and a dependent is stalled
        for (int i = 0; i < 6; i++)
            step("idle4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mdu7b", 1, 0, 1, 1, 7, 0, 0, 0, 0, 0);
        step("dep7b", 1, 0, 0, 1, 4, 7, 1, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk_quiet("mid_rst");
        @(posedge clk);
        #1;
        chk_quiet("mid_rst_edge");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cyc += 2;
        step("dep7c", 1, 0, 0, 1, 4, 7, 1, 0, 0, 0);
        chk("post_rst_nostall", 32'(stall_d), 0);

        // random traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            md = !ld && ($urandom_range(0, 4) == 0);
            step("rnd",
                 $urandom_range(0, 9) < 8, ld, md,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom),
                 $urandom_range(0, 3), 1'($urandom),
                 $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width (2**ADDR_W architectural registers).
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..3, bubbles a load result needs before a dependent may issue.
REQ-003 SHALL have parameter MDU_LAT, default 4, range 2..15, cycles a multi-cycle mul/div op occupies the MDU and hides its result.
REQ-004 SHALL have parameter CNT_W, default 16, stall performance counter width.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rs1_d, rs2_d  input  ADDR_W each  D-stage source registers.
REQ-008 use_rs1_d, use_rs2_d  input  1 each  D-stage instruction reads that source.
REQ-009 rd_d  input  ADDR_W  D-stage destination.
REQ-010 valid_d, regwrite_d, is_load_d, is_mdu_d  input  1 each  D-stage instruction valid, writes rd, is a load, is an MDU op.
REQ-011 pcsrc_e  input  1  taken branch/jump resolved in E.
REQ-012 stall_f, stall_d  output  1 each  hold PC and IF/ID.
REQ-013 flush_d, flush_e  output  1 each  clear IF/ID and ID/EX.
REQ-014 mdu_start  output  1  one-cycle pulse launching an MDU op into E.
REQ-015 mdu_busy  output  1  MDU occupied.
REQ-016 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-017 SHALL keep per-register pending counter pend[r] (4 bits); register 0 never pending.
REQ-018 Issue = valid_d & ~stall_d & ~flush_d; on issue with regwrite_d and rd_d!=0: pend[rd_d] <= LOAD_LAT if is_load_d, MDU_LAT if is_mdu_d, else unchanged (ALU results forward, no stall).
REQ-019 Each non-issuing cycle, nonzero pend[r] decrements by 1; issue write to same register takes priority over decrement.
REQ-020 RAW: stall_d SHALL assert when valid_d and (use_rs1_d & pend[rs1_d]!=0 or use_rs2_d & pend[rs2_d]!=0).
REQ-021 WAW: stall_d SHALL assert when valid_d & regwrite_d & rd_d!=0 and pend[rd_d] exceeds the issuing op's latency (ALU=0).
REQ-022 Structural: stall_d SHALL assert when valid_d & is_mdu_d & mdu_busy.
REQ-023 MDU FSM states IDLE, BUSY: IDLE->BUSY on issue of an MDU op (mdu_start=1 that cycle, busy counter loaded MDU_LAT-1); BUSY counts down, ->IDLE when counter reaches 0; mdu_busy=1 in BUSY.
REQ-024 stall_f SHALL equal stall_d; flush_e SHALL be 1 whenever stall_d=1 (bubble insertion).
REQ-025 pcsrc_e SHALL force flush_d=1, flush_e=1, stall_f=0, stall_d=0, overriding any hazard that cycle; no issue occurs.
REQ-026 A flush SHALL NOT cancel pending counters or an in-flight MDU op (they belong to older instructions).
REQ-027 All stall/flush outputs combinational from current inputs and state, zero added latency.
REQ-028 stall_cnt increments on each cycle stall_d=1, saturates at all-ones.

Reset
REQ-029 On reset low, asynchronously: all pend[r]=0, FSM IDLE, busy counter 0, mdu_start=0, stall_cnt=0; outputs then stall_f=stall_d=flush_d=flush_e=0, mdu_busy=0.
REQ-030 Reset mid-stall or mid-MDU SHALL abandon state; first cycle after release behaves as empty scoreboard.

Structure
REQ-031 Package hazard_pkg SHALL hold the MDU state enum, latency class enum (ALU/LOAD/MDU) and default latency constants.
REQ-032 Sub-module reg_scoreboard SHALL implement the pend[] array (set/decrement/lookup ports); hazard_scoreboard holds FSM, priority logic, counter.

Verification
REQ-033 Load x5 issued, next D reads x5 (LOAD_LAT=1) -> exactly one cycle stall_d=1, flush_e=1; issue following cycle; stall_cnt=1.
REQ-034 MDU op to x7 (MDU_LAT=4) then dependent on x7 -> mdu_start pulse, 4 stall cycles, issue on 5th; second MDU op while busy stalls until IDLE.
REQ-035 Load-use stall and pcsrc_e=1 same cycle -> flush_d=1, flush_e=1, stall_d=0; pend[x5] still decrements to 0.
REQ-036 MDU to x9 then ALU writing x9 -> WAW stall until pend[x9]=0; rd_d=0 or rs=x0 with a load to x0 -> never stalls.
REQ-037 Assert reset low during MDU BUSY with dependent stalled -> all outputs 0 immediately; after release dependent issues with no stall.
